// File: rtl/pipeline_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch funct3,
// forward selects and the bus timeout limit.
package pipeline_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [7:0] BUS_TIMEOUT = 8'd255;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_WAIT = 1'b1
   } bus_state_e;

   function automatic logic [31:0] fwd_mux(
      input logic [1:0]  sel,
      input logic [31:0] rf,
      input logic [31:0] wb,
      input logic [31:0] mem
   );
      logic [31:0] r;
      case (sel)
         FWD_WB:  r = wb;
         FWD_MEM: r = mem;
         default: r = rf;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; undefined op codes produce zero.
module alu
   import pipeline_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  ctrl,
   output logic [31:0] y
);

   logic [4:0] sh;

   assign sh = b[4:0];

   always_comb begin
      y = '0;
      case (ctrl)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_SLL:  y = a << sh;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $unsigned($signed(a) >>> sh);
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, E->M
// register and a bus-wait FSM that stalls while a peripheral access is open.
module execute_stage
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        JumpE,
   input  logic        JalrE,
   input  logic        BranchE,
   input  logic        ALUSrcE,
   input  logic        transEnE,
   input  logic        lui_enE,
   input  logic [1:0]  ResultSrcE,
   input  logic [1:0]  MemStrobeE,
   input  logic [3:0]  ALUControlE,
   input  logic [2:0]  Funct3E,
   input  logic [31:0] RD1E,
   input  logic [31:0] RD2E,
   input  logic [31:0] PCE,
   input  logic [31:0] ImmExtE,
   input  logic [31:0] PCPlus4E,
   input  logic [31:0] ResultW,
   input  logic [4:0]  RdE,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic        bus_done,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        BusStall,
   output logic        BusErr,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        transEnM,
   output logic [1:0]  ResultSrcM,
   output logic [1:0]  MemStrobeM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [31:0] PCPlus4M,
   output logic [4:0]  RdM
);

   logic [31:0] srca;
   logic [31:0] srcb;
   logic [31:0] wdata;
   logic [31:0] alu_y;
   logic [31:0] jalr_sum;
   logic        cond;
   logic        leave;
   logic        adv;
   logic [7:0]  cnt;
   bus_state_e  state;

   assign srca  = lui_enE ? '0 :
                  fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
   assign wdata = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
   assign srcb  = ALUSrcE ? ImmExtE : wdata;

   alu u_alu (
      .a    (srca),
      .b    (srcb),
      .ctrl (ALUControlE),
      .y    (alu_y)
   );

   always_comb begin
      cond = 1'b0;
      case (Funct3E)
         F3_BEQ:  cond = (srca == srcb);
         F3_BNE:  cond = (srca != srcb);
         F3_BLT:  cond = ($signed(srca) < $signed(srcb));
         F3_BGE:  cond = ($signed(srca) >= $signed(srcb));
         F3_BLTU: cond = (srca < srcb);
         F3_BGEU: cond = (srca >= srcb);
         default: cond = 1'b0;
      endcase
   end

   assign jalr_sum  = srca + ImmExtE;
   assign PCTargetE = JalrE ? {jalr_sum[31:1], 1'b0} : PCE + ImmExtE;
   assign PCSrcE    = (JumpE | (BranchE & cond)) & ~BusStall;

   assign BusStall = (state == BUS_WAIT);
   // the completing cycle also advances E into M, so back-to-back
   // bus accesses chain without an IDLE bubble
   assign leave    = BusStall & (bus_done | (cnt == BUS_TIMEOUT));
   assign adv      = ~BusStall | leave;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= BUS_IDLE;
         cnt    <= '0;
         BusErr <= 1'b0;
      end else begin
         BusErr <= 1'b0;
         case (state)
            BUS_IDLE: begin
               if (transEnE) begin
                  state <= BUS_WAIT;
                  cnt   <= '0;
               end
            end
            BUS_WAIT: begin
               if (leave) begin
                  BusErr <= ~bus_done;
                  cnt    <= '0;
                  state  <= transEnE ? BUS_WAIT : BUS_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= BUS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         transEnM   <= 1'b0;
         ResultSrcM <= '0;
         MemStrobeM <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
         RdM        <= '0;
      end else if (adv) begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         transEnM   <= transEnE;
         ResultSrcM <= ResultSrcE;
         MemStrobeM <= MemStrobeE;
         ALUResultM <= alu_y;
         WriteDataM <= wdata;
         PCPlus4M   <= PCPlus4E;
         RdM        <= RdE;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, forwarding, branches,
// bus stall / timeout and asynchronous reset.
module tb_execute_stage;

   logic        clk;
   logic        rst;
   logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE;
   logic        ALUSrcE, transEnE, lui_enE;
   logic [1:0]  ResultSrcE, MemStrobeE;
   logic [3:0]  ALUControlE;
   logic [2:0]  Funct3E;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        bus_done;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        BusStall, BusErr;
   logic        RegWriteM, MemWriteM, transEnM;
   logic [1:0]  ResultSrcM, MemStrobeM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;

   int checks = 0;
   int errors = 0;
   int n;

   execute_stage dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteE   (RegWriteE),
      .MemWriteE   (MemWriteE),
      .JumpE       (JumpE),
      .JalrE       (JalrE),
      .BranchE     (BranchE),
      .ALUSrcE     (ALUSrcE),
      .transEnE    (transEnE),
      .lui_enE     (lui_enE),
      .ResultSrcE  (ResultSrcE),
      .MemStrobeE  (MemStrobeE),
      .ALUControlE (ALUControlE),
      .Funct3E     (Funct3E),
      .RD1E        (RD1E),
      .RD2E        (RD2E),
      .PCE         (PCE),
      .ImmExtE     (ImmExtE),
      .PCPlus4E    (PCPlus4E),
      .ResultW     (ResultW),
      .RdE         (RdE),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .bus_done    (bus_done),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .BusStall    (BusStall),
      .BusErr      (BusErr),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .transEnM    (transEnM),
      .ResultSrcM  (ResultSrcM),
      .MemStrobeM  (MemStrobeM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .PCPlus4M    (PCPlus4M),
      .RdM         (RdM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] exp,
                          input string tag);
      RD1E = a;
      RD2E = b;
      ALUControlE = op;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ALUSrcE = 1'b0;
      lui_enE = 1'b0;
      step();
      chk(tag, ALUResultM, exp);
   endtask

   initial begin
      rst = 1'b1;
      RegWriteE = 0; MemWriteE = 0; JumpE = 0; JalrE = 0; BranchE = 0;
      ALUSrcE = 0; transEnE = 0; lui_enE = 0;
      ResultSrcE = 0; MemStrobeE = 0; ALUControlE = 0; Funct3E = 0;
      RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0;
      ResultW = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; bus_done = 0;
      #1;
      chk("rst_alu", ALUResultM, 32'h0);
      chk("rst_stall", {31'b0, BusStall}, 32'h0);
      chk("rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
      chk("rst_buserr", {31'b0, BusErr}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 7 - 5
      RegWriteE = 1; ResultSrcE = 2'b01; MemStrobeE = 2'b10;
      RdE = 5'd5; PCPlus4E = 32'h44;
      alu_vec(32'd7, 32'd5, 4'b0001, 32'd2, "sub_7_5");
      chk("wdata_m", WriteDataM, 32'd5);
      chk("rd_m", {27'b0, RdM}, 32'd5);
      chk("pc4_m", PCPlus4M, 32'h44);
      chk("ctl_m", {26'b0, RegWriteM, MemWriteM, ResultSrcM, MemStrobeM},
          32'b10_01_10);

      // forwarding from M
      alu_vec(32'h10, 32'h0, 4'b0000, 32'h10, "add_seed");
      RD1E = 32'hFFFF; ForwardAE = 2'b10; ImmExtE = 32'd4; ALUSrcE = 1;
      ALUControlE = 4'b0000;
      step();
      chk("fwd_mem_add", ALUResultM, 32'h14);

      ResultW = 32'h100; ForwardAE = 2'b01; ImmExtE = 32'd1;
      step();
      chk("fwd_wb_add", ALUResultM, 32'h101);
      ForwardAE = 2'b11; RD1E = 32'h30;
      step();
      chk("fwd_11_rf", ALUResultM, 32'h31);
      ForwardAE = 2'b00; ALUSrcE = 0; RD2E = 32'h7; ForwardBE = 2'b01;
      RD1E = 32'h1;
      step();
      chk("fwdb_wb", WriteDataM, 32'h100);
      chk("fwdb_wb_alu", ALUResultM, 32'h101);
      ForwardBE = 2'b00;

      alu_vec(32'h0, 32'h1, 4'b0001, 32'hFFFFFFFF, "sub_wrap");
      alu_vec(32'hF0F0, 32'hFF00, 4'b0100, 32'h0FF0, "xor");
      alu_vec(32'hF0F0, 32'hFF00, 4'b0010, 32'hF000, "and");
      alu_vec(32'hF0F0, 32'hFF00, 4'b0011, 32'hFFF0, "or");
      alu_vec(32'hFFFFFFFF, 32'h1, 4'b0101, 32'h1, "slt_neg");
      alu_vec(32'hFFFFFFFF, 32'h1, 4'b0110, 32'h0, "sltu_big");
      alu_vec(32'h1, 32'h3F, 4'b0111, 32'h80000000, "sll_31");
      alu_vec(32'h80000000, 32'h4, 4'b1000, 32'h08000000, "srl_4");
      alu_vec(32'h80000000, 32'h4, 4'b1001, 32'hF8000000, "sra_4");
      alu_vec(32'h1234, 32'h1, 4'b1111, 32'h0, "op_undef");

      RD1E = 32'hDEAD; lui_enE = 1; ALUSrcE = 1; ImmExtE = 32'h12345000;
      ALUControlE = 4'b0000;
      step();
      chk("lui", ALUResultM, 32'h12345000);
      lui_enE = 0; ALUSrcE = 0;

      // branch resolution is combinational
      BranchE = 1; Funct3E = 3'b000; RD1E = 3; RD2E = 3;
      PCE = 32'h100; ImmExtE = 32'h20;
      #1;
      chk("beq_taken", {31'b0, PCSrcE}, 32'h1);
      chk("beq_target", PCTargetE, 32'h120);
      Funct3E = 3'b001; #1;
      chk("bne_not", {31'b0, PCSrcE}, 32'h0);
      Funct3E = 3'b100; RD1E = 32'hFFFFFFFF; RD2E = 1; #1;
      chk("blt_signed", {31'b0, PCSrcE}, 32'h1);
      Funct3E = 3'b110; #1;
      chk("bltu_not", {31'b0, PCSrcE}, 32'h0);
      Funct3E = 3'b111; #1;
      chk("bgeu_taken", {31'b0, PCSrcE}, 32'h1);
      Funct3E = 3'b010; RD1E = 3; RD2E = 3; #1;
      chk("f3_010_false", {31'b0, PCSrcE}, 32'h0);
      BranchE = 0; JumpE = 1; JalrE = 1; RD1E = 32'h1001; ImmExtE = 32'h10;
      #1;
      chk("jalr_target", PCTargetE, 32'h1010);
      chk("jump_taken", {31'b0, PCSrcE}, 32'h1);
      JalrE = 0;

      // store held for 4 wait cycles
      JumpE = 0; transEnE = 1; MemWriteE = 1; RD1E = 32'h200;
      RD2E = 32'hDEADBEEF; ImmExtE = 32'h8; ALUSrcE = 1;
      step();
      chk("st_alu", ALUResultM, 32'h208);
      chk("st_wdata", WriteDataM, 32'hDEADBEEF);
      chk("st_memw", {30'b0, MemWriteM, transEnM}, 32'h3);
      transEnE = 0; MemWriteE = 0; JumpE = 1; RD1E = 32'h999;
      ImmExtE = 32'h0; RD2E = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus_done = 1;
         #1;
         chk("st_stall", {31'b0, BusStall}, 32'h1);
         chk("st_pcsrc_gated", {31'b0, PCSrcE}, 32'h0);
         chk("st_hold", ALUResultM, 32'h208);
         if (i < 3) step();
      end
      JumpE = 0;
      step();
      bus_done = 0;
      chk("st_done_idle", {31'b0, BusStall}, 32'h0);
      chk("st_adv", ALUResultM, 32'h999);
      chk("st_no_err", {31'b0, BusErr}, 32'h0);

      bus_done = 1;
      step();
      chk("done_idle_ign", {31'b0, BusStall}, 32'h0);
      bus_done = 0;

      // back-to-back accesses
      transEnE = 1; RD1E = 32'h40;
      step();
      chk("b2b_first", {31'b0, BusStall}, 32'h1);
      RD1E = 32'h50; bus_done = 1;
      step();
      chk("b2b_rewait", {31'b0, BusStall}, 32'h1);
      chk("b2b_capture", ALUResultM, 32'h50);
      transEnE = 0; RD1E = 32'h60;
      step();
      bus_done = 0;
      chk("b2b_idle", {31'b0, BusStall}, 32'h0);
      chk("b2b_last", ALUResultM, 32'h60);

      // timeout with no completion
      transEnE = 1;
      step();
      transEnE = 0;
      n = 0;
      while (BusStall && n < 400) begin
         if (BusErr) n = 1000;
         n++;
         step();
      end
      chk("to_cycles", n, 32'd256);
      chk("to_idle", {31'b0, BusStall}, 32'h0);
      chk("to_err_pulse", {31'b0, BusErr}, 32'h1);
      step();
      chk("to_err_clear", {31'b0, BusErr}, 32'h0);

      // completion on the timeout cycle wins
      transEnE = 1;
      step();
      transEnE = 0;
      for (int i = 0; i < 255; i++) step();
      chk("to_edge_stall", {31'b0, BusStall}, 32'h1);
      bus_done = 1;
      step();
      bus_done = 0;
      chk("to_edge_idle", {31'b0, BusStall}, 32'h0);
      chk("to_edge_noerr", {31'b0, BusErr}, 32'h0);

      // async reset in wait cycle 3
      transEnE = 1; MemWriteE = 1; RD1E = 32'h77;
      step();
      transEnE = 0; MemWriteE = 0;
      step();
      step();
      chk("rst_pre_stall", {31'b0, BusStall}, 32'h1);
      #2;
      rst = 1;
      #1;
      chk("arst_stall", {31'b0, BusStall}, 32'h0);
      chk("arst_alu", ALUResultM, 32'h0);
      chk("arst_wdata", WriteDataM, 32'h0);
      chk("arst_ctl", {20'b0, RegWriteM, MemWriteM, transEnM, ResultSrcM,
                       MemStrobeM, RdM}, 32'h0);
      chk("arst_pc4", PCPlus4M, 32'h0);
      chk("arst_pcsrc", {30'b0, PCSrcE, BusErr}, 32'h0);
      step();
      rst = 0;
      step();
      chk("post_rst_stall", {31'b0, BusStall}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
